// File: rtl/stump_mem_arbiter_if.sv
// stump_mem_arbiter_if: requester handshakes for both ports plus the shared memory bus
interface stump_mem_arbiter_if;
    logic        req0, req1;
    logic        wen0, wen1;
    logic [15:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1;
    logic        ack0, ack1;
    logic [15:0] rdata;
    logic [15:0] address;
    logic [15:0] data_out;
    logic        mem_wen, mem_ren;
    logic [15:0] data_in;
    modport master (
        output req0, req1, wen0, wen1, addr0, addr1, wdata0, wdata1, data_in,
        input  gnt0, gnt1, ack0, ack1, rdata, address, data_out, mem_wen, mem_ren
    );
    modport slave (
        input  req0, req1, wen0, wen1, addr0, addr1, wdata0, wdata1, data_in,
        output gnt0, gnt1, ack0, ack1, rdata, address, data_out, mem_wen, mem_ren
    );
endinterface

// File: rtl/stump_mem_arbiter.sv
// stump_mem_arbiter: processor-priority two-port memory arbiter with bounded port-1 starvation
module stump_mem_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input logic                clk,
    input logic                rst,
    stump_mem_arbiter_if.slave bus
);
    logic [3:0]  hold_q, hold_d;
    logic        pend_valid_q, pend_valid_d;
    logic        pend_port_q, pend_port_d;
    logic        pend_read_q, pend_read_d;
    logic [15:0] rdata_q, rdata_d;
    logic        sel1, any, wen, read_ack;
    always_comb begin
        sel1         = bus.req1 && (!bus.req0 || hold_q == 4'(MAX_HOLD));
        bus.gnt1     = !rst && sel1;
        bus.gnt0     = !rst && bus.req0 && !sel1;
        any          = bus.gnt0 || bus.gnt1;
        wen          = sel1 ? bus.wen1 : bus.wen0;
        bus.address  = any ? (sel1 ? bus.addr1 : bus.addr0) : '0;
        bus.data_out = any ? (sel1 ? bus.wdata1 : bus.wdata0) : '0;
        bus.mem_wen  = any && wen;
        bus.mem_ren  = any && !wen;
        hold_d       = (bus.gnt0 && bus.req1) ? (hold_q == 4'(MAX_HOLD) ? hold_q : hold_q + 4'd1) : 4'd0;
        pend_valid_d = any;
        pend_port_d  = bus.gnt1;
        pend_read_d  = any && !wen;
        // memory data arrives during the ack cycle; forward it and keep a copy for later write acks
        read_ack     = pend_valid_q && pend_read_q;
        rdata_d      = read_ack ? bus.data_in : rdata_q;
        bus.rdata    = rst ? '0 : rdata_d;
        bus.ack0     = !rst && pend_valid_q && !pend_port_q;
        bus.ack1     = !rst && pend_valid_q && pend_port_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_port_q  <= 1'b0;
            pend_read_q  <= 1'b0;
            rdata_q      <= '0;
        end else begin
            hold_q       <= hold_d;
            pend_valid_q <= pend_valid_d;
            pend_port_q  <= pend_port_d;
            pend_read_q  <= pend_read_d;
            rdata_q      <= rdata_d;
        end
    end
endmodule

// File: tb/tb_stump_mem_arbiter.sv
// tb_stump_mem_arbiter: vector table, hand sequences and randomised traffic against a reference model
module tb_stump_mem_arbiter;
    localparam int MH = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    stump_mem_arbiter_if bus ();
    stump_mem_arbiter #(.MAX_HOLD(MH)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    int errors = 0;
    int checks = 0;
    always @(posedge clk) begin
        if (bus.mem_wen) mem[bus.address[7:0]] <= bus.data_out;
        bus.data_in <= bus.mem_ren ? mem[bus.address[7:0]] : 16'($urandom);
    end
    task automatic chk1(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, a, e);
        end
    endtask
    task automatic chk16(input string n, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    task automatic drive(input logic r, input logic q0, input logic q1, input logic w0, input logic w1,
                         input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] d0, input logic [15:0] d1);
        rst = r;
        bus.req0 = q0; bus.req1 = q1; bus.wen0 = w0; bus.wen1 = w1;
        bus.addr0 = a0; bus.addr1 = a1; bus.wdata0 = d0; bus.wdata1 = d1;
    endtask
    typedef struct {
        logic        rst, req0, req1, wen0, wen1;
        logic [15:0] a0, a1, wd;
        logic        g0, g1, k0, k1, mw, mr;
        logic [15:0] ea, ed, rd;
    } vec_t;
    vec_t vec [11];
    initial begin
        logic [1:0]  rq, wn, got;
        logic [15:0] ad [2];
        logic [15:0] wd [2];
        logic        pv, pp, pr, e0, e1;
        logic [15:0] pd;
        int          wait1, act_wait, gp;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 7 + 3);
        mem[8'h10] = 16'hBEEF;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        //          rst q0 q1 w0 w1 a0     a1     wd        g0 g1 k0 k1 mw mr ea     ed        rd
        vec[0]  = '{1, 0, 0, 0, 0, 0,     0,     0,        0, 0, 0, 0, 0, 0, 0,     0,        0};
        vec[1]  = '{0, 0, 0, 0, 0, 0,     0,     0,        0, 0, 0, 0, 0, 0, 0,     0,        0};
        vec[2]  = '{0, 1, 0, 0, 0, 16'h10, 0,    0,        1, 0, 0, 0, 0, 1, 16'h10, 0,       0};
        vec[3]  = '{0, 0, 1, 0, 1, 0,     16'h20, 16'h1234, 0, 1, 1, 0, 1, 0, 16'h20, 16'h1234, 16'hBEEF};
        vec[4]  = '{0, 1, 0, 0, 0, 16'h20, 0,    0,        1, 0, 0, 1, 0, 1, 16'h20, 0,       16'hBEEF};
        vec[5]  = '{0, 0, 0, 0, 0, 0,     0,     0,        0, 0, 1, 0, 0, 0, 0,     0,        16'h1234};
        vec[6]  = '{0, 1, 0, 0, 0, 16'h10, 0,    0,        1, 0, 0, 0, 0, 1, 16'h10, 0,       16'h1234};
        vec[7]  = '{1, 1, 0, 0, 0, 16'h10, 0,    0,        0, 0, 0, 0, 0, 0, 0,     0,        0};
        vec[8]  = '{0, 1, 0, 0, 0, 16'h20, 0,    0,        1, 0, 0, 0, 0, 1, 16'h20, 0,       0};
        vec[9]  = '{0, 0, 0, 0, 0, 0,     0,     0,        0, 0, 1, 0, 0, 0, 0,     0,        16'h1234};
        vec[10] = '{0, 0, 0, 0, 0, 0,     0,     0,        0, 0, 0, 0, 0, 0, 0,     0,        16'h1234};
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            drive(vec[i].rst, vec[i].req0, vec[i].req1, vec[i].wen0, vec[i].wen1,
                  vec[i].a0, vec[i].a1, vec[i].wd, vec[i].wd);
            #3;
            chk1($sformatf("vec%0d gnt0", i), bus.gnt0, vec[i].g0);
            chk1($sformatf("vec%0d gnt1", i), bus.gnt1, vec[i].g1);
            chk1($sformatf("vec%0d ack0", i), bus.ack0, vec[i].k0);
            chk1($sformatf("vec%0d ack1", i), bus.ack1, vec[i].k1);
            chk1($sformatf("vec%0d mem_wen", i), bus.mem_wen, vec[i].mw);
            chk1($sformatf("vec%0d mem_ren", i), bus.mem_ren, vec[i].mr);
            chk16($sformatf("vec%0d address", i), bus.address, vec[i].ea);
            chk16($sformatf("vec%0d data_out", i), bus.data_out, vec[i].ed);
            chk16($sformatf("vec%0d rdata", i), bus.rdata, vec[i].rd);
        end
        // both ports requesting continuously: port 1 wins every fifth cycle
        @(posedge clk); #1; drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            drive(0, 1, 1, 0, 0, 16'h1, 16'h2, 0, 0);
            #3;
            chk1($sformatf("cont%0d gnt0", k), bus.gnt0, (k % 5) != 4);
            chk1($sformatf("cont%0d gnt1", k), bus.gnt1, (k % 5) == 4);
            chk1($sformatf("cont%0d ack0", k), bus.ack0, k > 0 && ((k - 1) % 5) != 4);
            chk1($sformatf("cont%0d ack1", k), bus.ack1, k > 0 && ((k - 1) % 5) == 4);
        end
        // port 1 alone: granted every cycle, hold counter never moves
        @(posedge clk); #1; drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            drive(0, 0, k < 6, 0, 1, 0, 16'h3, 16'(k), 16'(k));
            #3;
            chk1($sformatf("solo%0d gnt1", k), bus.gnt1, k < 6);
            chk1($sformatf("solo%0d ack1", k), bus.ack1, k > 0);
            chk1($sformatf("solo%0d hold", k), dut.hold_q == 4'd0, 1'b1);
        end
        @(posedge clk); #1; drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        rq = '0; got = '0; pv = 1'b0; pp = 1'b0; pr = 1'b0; pd = '0;
        wait1 = 0; act_wait = 0;
        ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0; wn = '0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (!rq[p] || got[p]) begin
                    rq[p] = $urandom_range(0, 99) < (p == 0 ? 75 : 45);
                    wn[p] = 1'($urandom_range(0, 1));
                    ad[p] = 16'($urandom_range(0, 15));
                    wd[p] = 16'($urandom);
                end
            end
            drive(0, rq[0], rq[1], wn[0], wn[1], ad[0], ad[1], wd[0], wd[1]);
            #3;
            e1 = rq[1] && (!rq[0] || wait1 == MH);
            e0 = rq[0] && !e1;
            chk1($sformatf("rnd%0d gnt0", c), bus.gnt0, e0);
            chk1($sformatf("rnd%0d gnt1", c), bus.gnt1, e1);
            chk1($sformatf("rnd%0d ack0", c), bus.ack0, pv && !pp);
            chk1($sformatf("rnd%0d ack1", c), bus.ack1, pv && pp);
            if (pv && pr) chk16($sformatf("rnd%0d rdata", c), bus.rdata, pd);
            gp = e1 ? 1 : 0;
            if (e0 || e1) begin
                chk16($sformatf("rnd%0d address", c), bus.address, ad[gp]);
                chk1($sformatf("rnd%0d mem_wen", c), bus.mem_wen, wn[gp]);
                chk1($sformatf("rnd%0d mem_ren", c), bus.mem_ren, !wn[gp]);
                if (wn[gp]) chk16($sformatf("rnd%0d data_out", c), bus.data_out, wd[gp]);
            end
            if (bus.gnt1) chk1($sformatf("rnd%0d p1 wait", c), act_wait <= MH, 1'b1);
            act_wait = (rq[1] && !bus.gnt1) ? act_wait + 1 : 0;
            wait1 = (rq[1] && !e1) ? wait1 + 1 : 0;
            pv = e0 || e1;
            pp = e1;
            pr = pv && !wn[gp];
            if (pv && wn[gp]) ref_mem[ad[gp][7:0]] = wd[gp];
            if (pr) pd = ref_mem[ad[gp][7:0]];
            got = {e1, e0};
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stump_mem_arbiter.md
# stump_mem_arbiter

Two-port memory arbiter that shares the Stump single-port memory bus between the processor (port 0) and a second bus master such as the program loader or debug DMA (port 1). It sits between the `Stump` top level and the memory model. Each requester issues one-word read/write transactions with a req/gnt/ack handshake. The arbiter grants at most one transaction per cycle, favouring the processor with a bounded-starvation guarantee for port 1.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive port-0 grants while port 1 is waiting (range 1–15).
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high master reset.
- `req0` / `req1` in 1: transaction request; held high with fields stable until `gntN` is sampled high.
- `wen0` / `wen1` in 1: 1 = write, 0 = read.
- `addr0` / `addr1` in 16: word address.
- `wdata0` / `wdata1` in 16: write data.
- `gnt0` / `gnt1` out 1: combinational grant; the transaction is accepted in this cycle.
- `ack0` / `ack1` out 1: registered completion, high for exactly one cycle.
- `rdata` out 16: registered read data, shared by both ports, valid while `ackN` is high.
- `address` out 16: memory address.
- `data_out` out 16: memory write data.
- `mem_wen` out 1: memory write enable.
- `mem_ren` out 1: memory read enable.
- `data_in` in 16: memory read data, valid the cycle after `mem_ren`.

## Operation
**Arbitration** is evaluated combinationally each cycle from `req0`, `req1` and the hold counter `hold_cnt` (4 bits):
- Only `req0` high: grant port 0.
- Only `req1` high: grant port 1.
- Both high and `hold_cnt < MAX_HOLD`: grant port 0.
- Both high and `hold_cnt == MAX_HOLD`: grant port 1.
- At most one of `gnt0`/`gnt1` is ever high. `gntN` is never high unless `reqN` is high.

**hold_cnt update**, on the clock edge:
- Port 0 granted while `req1` high: increment, saturating at `MAX_HOLD`.
- Port 1 granted: clear to 0.
- No request from port 1, or idle: clear to 0.

**Memory drive** in the grant cycle:
- `address`, `data_out` and the `mem_wen`/`mem_ren` pair are muxed from the granted port.
- Read: `mem_ren=1`, `mem_wen=0`.
- Write: `mem_wen=1`, `mem_ren=0`.
- No grant: `mem_wen=0`, `mem_ren=0`, `address=0`, `data_out=0`.

**Completion pipeline** is one stage, holding `pend_valid`, `pend_port` and `pend_read`:
- The cycle after a grant, `ack<pend_port>` is high for one cycle.
- For a read, `rdata` is captured from `data_in` on the edge after the ack... captured so that it is valid during the ack cycle.
- For a write, `rdata` holds its previous value.

**Back-to-back transactions**: a requester may present a new request in the same cycle as its ack. The arbiter accepts one transaction per cycle with no dead cycles.

**Reset**:
- Clears `hold_cnt`, `pend_valid`, `ack0`, `ack1` and `rdata` (to 0).
- A transaction granted in the cycle `rst` is high produces no ack.
- A pending ack due in the cycle after reset is suppressed.
- The combinational `gnt`/memory outputs are forced low (`address`/`data_out` = 0) while `rst` is high.

## Timing
- Reset values:
  - `gnt0=gnt1=0`, `ack0=ack1=0`, `rdata=0`.
  - `mem_wen=mem_ren=0`, `address=0`, `data_out=0`.
- Request-to-grant latency is 0 cycles when the port wins arbitration.
- Grant-to-ack latency is exactly 1 cycle, for both reads and writes.
- Throughput is 1 transaction per cycle.
- Worst-case port-1 wait under continuous port-0 traffic is `MAX_HOLD` cycles.
- Port-0 worst-case wait is 1 cycle.
- Write data reaches memory in the grant cycle. A read of the same address granted in the next cycle returns the new data.

## Test plan
- Reset, then idle: all outputs 0. `req0=1`, `wen0=0`, `addr0=16'h0010` with memory holding `16'hBEEF` → `gnt0` and `mem_ren` high in cycle N, `ack0=1` and `rdata=16'hBEEF` in N+1.
- Port-1 write `addr1=16'h0020`, `wdata1=16'h1234`, then port-0 read of `16'h0020` the next cycle → `mem_wen` asserted for one cycle, then `ack0` with `rdata=16'h1234`, no idle cycle between.
- `req0` and `req1` held continuously high, `MAX_HOLD=4` → grant sequence 0,0,0,0,1,0,0,0,0,1…; `gnt0` and `gnt1` never high together.
- Only `req1` high for 6 cycles → `gnt1` every cycle, `ack1` every cycle from the second onward, `hold_cnt` stays 0.
- `rst` asserted in the cycle after a port-0 read grant → no `ack0`, `rdata=0`; the next post-reset request is serviced normally.
- Randomised `req`/`wen`/`addr` on both ports against a reference memory model checks:
  - every grant gets exactly one ack one cycle later, on the correct port;
  - read data matches the model;
  - port-1 wait ≤ `MAX_HOLD`.
